axi_lite_reg_slave: RTL and testbench

AXI4-Lite slave (responder) exposing NUM_REGS read/write 32-bit registers to an AXI4-Lite master such as the VIP master agent in the block-design benches. It implements independent write and read channel controllers with full VALID/READY handshaking, byte strobes, and an SLVERR response for unmapped addresses. Register contents are also driven out in parallel for use by downstream user logic.

---
 rtl/axi_lite_pkg.sv | 16 +
 rtl/axi_lite_reg_slave.sv | 157 +++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and address helpers
// for the register-slave codebase slice.
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  function automatic logic [31:0] word_idx(
    input logic [31:0] addr
  );
    return addr >> 2;
  endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers,
// with byte strobes and SLVERR for unmapped word indices.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DW-1:0] regs_q [NUM_REGS];

  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          aw_held_q, aw_held_d;
  logic          w_held_q, w_held_d;
  logic          bvalid_q, bvalid_d;
  axi_resp_t     bresp_q, bresp_d;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  logic          aw_hs, w_hs, commit, wr_ok;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [31:0]   widx;

  logic          arready_q, rvalid_q;
  axi_resp_t     rresp_q;
  logic [DW-1:0] rdata_q;
  logic          ar_hs, rd_ok, rvalid_d;
  logic [31:0]   ridx;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // A freshly handshaken beat counts as held in the same cycle,
  // so simultaneous AW+W commits on the handshake edge.
  always_comb begin
    aw_hs     = S_AXI_AWVALID & awready_q;
    w_hs      = S_AXI_WVALID & wready_q;
    waddr     = aw_hs ? S_AXI_AWADDR : awaddr_q;
    wdata     = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb     = w_hs ? S_AXI_WSTRB : wstrb_q;
    widx      = word_idx(32'(waddr));
    wr_ok     = widx < 32'(NUM_REGS);
    commit    = (aw_hs | aw_held_q) & (w_hs | w_held_q);
    aw_held_d = (aw_hs | aw_held_q) & ~commit;
    w_held_d  = (w_hs | w_held_q) & ~commit;
    bvalid_d  = commit | (bvalid_q & ~S_AXI_BREADY);
    bresp_d   = bresp_q;
    if (commit) bresp_d = wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit && wr_ok) begin
        for (int b = 0; b < SW; b++) begin
          if (wstrb[b])
            regs_q[widx[RIDX_W-1:0]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    ar_hs    = S_AXI_ARVALID & arready_q;
    ridx     = word_idx(32'(S_AXI_ARADDR));
    rd_ok    = ridx < 32'(NUM_REGS);
    rvalid_d = ar_hs | (rvalid_q & ~S_AXI_RREADY);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= AXI_RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= ~rvalid_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_ok ? regs_q[ridx[RIDX_W-1:0]] : '0;
        rresp_q <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_out[DW*i +: DW] = regs_q[i];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: handshakes, strobes,
// backpressure, unmapped addresses and mid-transaction reset.
module tb_axi_lite_reg_slave;

  logic         clk;
  logic         rst_n;
  logic [5:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [5:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_out;

  int checks = 0;
  int errors = 0;

  logic [1:0]  resp;
  logic [31:0] rd;
  logic [31:0] held;

  axi_lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS(4)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .reg_out(reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [1:0] r);
    bit aw_ok, w_ok, aw_go, w_go;
    int n;
    aw_ok = 0; w_ok = 0; n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_ok && w_ok) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick(); n++;
      if (aw_go) begin awvalid = 1'b0; aw_ok = 1; end
      if (w_go) begin wvalid = 1'b0; w_ok = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    while (!bvalid && n < 40) begin tick(); n++; end
    r = bresp;
    chk("wr_done", {aw_ok, w_ok, bvalid}, 3'b111);
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [5:0] a, output logic [31:0] d,
                        output logic [1:0] r);
    bit ar_ok, ar_go;
    int n;
    ar_ok = 0; n = 0;
    araddr = a; arvalid = 1'b1;
    while (!ar_ok && n < 20) begin
      ar_go = arvalid && arready;
      tick(); n++;
      if (ar_go) begin arvalid = 1'b0; ar_ok = 1; end
    end
    arvalid = 1'b0;
    rready = 1'b1;
    while (!rvalid && n < 40) begin tick(); n++; end
    d = rdata; r = rresp;
    chk("rd_done", {ar_ok, rvalid}, 2'b11);
    tick();
    rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();

    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp, rdata}, 36'h0);
    chk("rst_regs", reg_out, 128'h0);

    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", {awready, wready, arready}, 3'b000);
    tick();
    chk("ready_post_edge", {awready, wready, arready}, 3'b111);

    axi_wr(6'h00, 32'h1, 4'hF, resp); chk("bresp0", resp, 2'b00);
    axi_wr(6'h04, 32'h2, 4'hF, resp); chk("bresp1", resp, 2'b00);
    axi_wr(6'h08, 32'h3, 4'hF, resp); chk("bresp2", resp, 2'b00);
    axi_wr(6'h0C, 32'h4, 4'hF, resp); chk("bresp3", resp, 2'b00);
    axi_rd(6'h00, rd, resp); chk("rd0", {resp, rd}, {2'b00, 32'h1});
    axi_rd(6'h04, rd, resp); chk("rd1", {resp, rd}, {2'b00, 32'h2});
    axi_rd(6'h08, rd, resp); chk("rd2", {resp, rd}, {2'b00, 32'h3});
    axi_rd(6'h0C, rd, resp); chk("rd3", {resp, rd}, {2'b00, 32'h4});
    chk("reg_out_seq", reg_out,
        {32'h4, 32'h3, 32'h2, 32'h1});

    axi_wr(6'h00, 32'hAABBCCDD, 4'hF, resp);
    axi_wr(6'h00, 32'h11223344, 4'h5, resp);
    chk("strb_bresp", resp, 2'b00);
    axi_rd(6'h00, rd, resp);
    chk("strb_rd", {resp, rd}, {2'b00, 32'hAA22CC44});

    // AW leads W by three cycles
    awaddr = 6'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw_first_ready", {awready, wready, bvalid}, 3'b010);
    repeat (3) tick();
    chk("aw_first_wait", {awready, bvalid}, 2'b00);
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("aw_first_b", {bvalid, bresp}, 3'b100);
    repeat (5) begin
      tick();
      chk("b_stall", {bvalid, bresp, awready, wready}, 5'b10000);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_release", {bvalid, awready, wready}, 3'b011);
    axi_rd(6'h08, rd, resp);
    chk("aw_first_rd", {resp, rd}, {2'b00, 32'h55});

    // W leads AW by two cycles
    wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("w_first_ready", {awready, wready, bvalid}, 3'b100);
    repeat (2) tick();
    awaddr = 6'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("w_first_b", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_rd(6'h0C, rd, resp);
    chk("w_first_rd", {resp, rd}, {2'b00, 32'h66});

    // read backpressure
    araddr = 6'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("r_first", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'h55});
    held = rdata;
    repeat (5) begin
      tick();
      chk("r_stall", {rvalid, arready, rdata}, {1'b1, 1'b0, 32'h55});
    end
    chk("r_stable", rdata, held);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("r_release", {rvalid, arready}, 2'b01);

    axi_wr(6'h10, 32'hDEAD, 4'hF, resp);
    chk("unmapped_bresp", resp, 2'b10);
    chk("unmapped_regs", reg_out,
        {32'h66, 32'h55, 32'h2, 32'hAA22CC44});
    axi_rd(6'h10, rd, resp);
    chk("unmapped_rd", {resp, rd}, {2'b10, 32'h0});

    axi_rd(6'h07, rd, resp);
    chk("unaligned_rd", {resp, rd}, {2'b00, 32'h2});

    axi_wr(6'h04, 32'hFFFFFFFF, 4'h0, resp);
    chk("strb0_bresp", resp, 2'b00);
    chk("strb0_regs", reg_out[63:32], 32'h2);

    // same-cycle read and write of reg0: read sees old value
    awaddr = 6'h00; wdata = 32'h77; wstrb = 4'hF;
    araddr = 6'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rw_same", {bvalid, rvalid, rdata},
        {1'b1, 1'b1, 32'hAA22CC44});
    chk("rw_reg_new", reg_out[31:0], 32'h77);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_rd(6'h00, rd, resp);
    chk("rw_after", {resp, rd}, {2'b00, 32'h77});

    // reset while a write response is pending
    awaddr = 6'h04; wdata = 32'h99; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_b", bvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b", {bvalid, awready, wready, arready}, 4'b0000);
    chk("mid_rst_regs", reg_out, 128'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    axi_rd(6'h00, rd, resp);
    chk("post_rst_rd", {resp, rd}, {2'b00, 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
